// File: rtl/telephone_timer.sv
// Tick prescaler and per-phase elapsed-tick counter feeding the dial and call
// timeout inputs of the telephone control FSM.
module telephone_timer #(
  parameter int PRESCALE   = 4,
  parameter int DIAL_LIMIT = 5,
  parameter int CALL_LIMIT = 250,
  parameter int CNT_W      = 8
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             clear,
  input  logic             dial_tone,
  input  logic             in_call,
  output logic             count_eql_5,
  output logic             count_eql_250,
  output logic [CNT_W-1:0] elapsed,
  output logic             tick
);

  localparam int PRE_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_TOP  = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W:0]   DIAL_LIM = (CNT_W + 1)'(DIAL_LIMIT);
  localparam logic [CNT_W:0]   CALL_LIM = (CNT_W + 1)'(CALL_LIMIT);

  typedef enum logic [1:0] {
    MODE_NONE = 2'd0,
    MODE_DIAL = 2'd1,
    MODE_CALL = 2'd2
  } mode_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  mode_t            mode, mode_q, mode_d;
  logic [PRE_W-1:0] pre_cnt, pre_d;
  logic [CNT_W-1:0] elapsed_d;
  logic [CNT_W:0]   elapsed_inc;
  logic             flag5_d, flag250_d;
  logic             run, restart, pre_top;

  assign run         = dial_tone | in_call;
  assign mode        = in_call ? MODE_CALL : MODE_DIAL;
  assign restart     = run & ~clear & (mode != mode_q);
  assign pre_top     = (pre_cnt == PRE_TOP);
  assign tick        = run & ~clear & ~restart & pre_top;
  // Unsaturated successor, so the limit compare is immune to counter wrap.
  assign elapsed_inc = {1'b0, elapsed} + (CNT_W + 1)'(1);

  always_comb begin
    mode_d    = mode_q;
    pre_d     = pre_cnt;
    elapsed_d = elapsed;
    flag5_d   = count_eql_5;
    flag250_d = count_eql_250;
    if (clear) begin
      mode_d    = MODE_NONE;
      pre_d     = '0;
      elapsed_d = '0;
      flag5_d   = 1'b0;
      flag250_d = 1'b0;
    end else if (restart) begin
      mode_d    = mode;
      pre_d     = '0;
      elapsed_d = '0;
      flag5_d   = 1'b0;
      flag250_d = 1'b0;
    end else if (run) begin
      if (pre_top) begin
        pre_d     = '0;
        elapsed_d = sat_inc(elapsed);
        if (mode_q == MODE_DIAL && elapsed_inc == DIAL_LIM) flag5_d = 1'b1;
        if (mode_q == MODE_CALL && elapsed_inc == CALL_LIM) flag250_d = 1'b1;
      end else begin
        pre_d = pre_cnt + PRE_W'(1);
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      mode_q        <= MODE_NONE;
      pre_cnt       <= '0;
      elapsed       <= '0;
      count_eql_5   <= 1'b0;
      count_eql_250 <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      pre_cnt       <= pre_d;
      elapsed       <= elapsed_d;
      count_eql_5   <= flag5_d;
      count_eql_250 <= flag250_d;
    end
  end

endmodule

// File: tb/tb_telephone_timer.sv
// Bench for telephone_timer: directed phase scenarios plus random phase traffic,
// two parameterisations driven in parallel against a run-cycle count model.
module tb_telephone_timer;

  localparam int P    = 4;
  localparam int DL   = 5;
  localparam int CL   = 10;
  localparam int CL_S = 7;

  logic       pclk = 1'b0;
  logic       presetn = 1'b0;
  logic       clear = 1'b0;
  logic       dial_tone = 1'b0;
  logic       in_call = 1'b0;
  logic       f5_m, f250_m, tick_m;
  logic [7:0] el_m;
  logic       f5_s, f250_s, tick_s;
  logic [2:0] el_s;

  always #5 pclk = ~pclk;

  telephone_timer #(.PRESCALE(P), .DIAL_LIMIT(DL), .CALL_LIMIT(CL), .CNT_W(8)) dut_m (
    .pclk(pclk), .presetn(presetn), .clear(clear), .dial_tone(dial_tone),
    .in_call(in_call), .count_eql_5(f5_m), .count_eql_250(f250_m),
    .elapsed(el_m), .tick(tick_m)
  );

  telephone_timer #(.PRESCALE(P), .DIAL_LIMIT(DL), .CALL_LIMIT(CL_S), .CNT_W(3)) dut_s (
    .pclk(pclk), .presetn(presetn), .clear(clear), .dial_tone(dial_tone),
    .in_call(in_call), .count_eql_5(f5_s), .count_eql_250(f250_s),
    .elapsed(el_s), .tick(tick_s)
  );

  int checks = 0;
  int errors = 0;
  // Model: current phase (0 none, 1 dial, 2 call) and run cycles counted since phase entry.
  int m_phase = 0;
  int m_rc = 0;
  logic s_tick, s_f5, s_f250, t_tick, t_f250;
  int   s_el, t_el;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Entered at posedge+1; drives one cycle, checks at the falling edge, advances model.
  task automatic cyc(input logic c, input logic d, input logic i);
    int   want, q;
    logic run, exp_tick;
    clear = c; dial_tone = d; in_call = i;
    run  = d | i;
    want = i ? 2 : (d ? 1 : 0);
    q    = m_rc / P;
    exp_tick = run && !c && (want == m_phase) && ((m_rc % P) == P - 1);
    @(negedge pclk);
    s_tick = tick_m; s_el = int'(el_m); s_f5 = f5_m; s_f250 = f250_m;
    t_tick = tick_s; t_el = int'(el_s); t_f250 = f250_s;
    chk("tick", tick_m, exp_tick);
    chk("elapsed", el_m, min_i(q, 255));
    chk("flag5", f5_m, (m_phase == 1) && (q >= DL));
    chk("flag250", f250_m, (m_phase == 2) && (q >= CL));
    chk("s_tick", tick_s, exp_tick);
    chk("s_elapsed", el_s, min_i(q, 7));
    chk("s_flag5", f5_s, (m_phase == 1) && (q >= DL));
    chk("s_flag250", f250_s, (m_phase == 2) && (q >= CL_S));
    @(posedge pclk);
    if (c) begin
      m_phase = 0; m_rc = 0;
    end else if (run && want != m_phase) begin
      m_phase = want; m_rc = 0;
    end else if (run) begin
      m_rc++;
    end
    #1;
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_tick"}, tick_m, 0);
    chk({tag, "_elapsed"}, el_m, 0);
    chk({tag, "_flag5"}, f5_m, 0);
    chk({tag, "_flag250"}, f250_m, 0);
    chk({tag, "_s_elapsed"}, el_s, 0);
    chk({tag, "_s_flag250"}, f250_s, 0);
  endtask

  // Entered at posedge+1; pulses presetn entirely between clock edges.
  task automatic async_reset();
    #1 presetn = 1'b0;
    #1 zero_outputs("arst");
    #1 presetn = 1'b1;
    m_phase = 0; m_rc = 0;
  endtask

  initial begin
    repeat (2) @(posedge pclk);
    #1;
    zero_outputs("reset");
    presetn = 1'b1;

    // Dial timeout from idle
    for (int k = 1; k <= 24; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("s1_tick", s_tick, (k == 5 || k == 9 || k == 13 || k == 17 || k == 21));
      chk("s1_flag250", s_f250, 0);
      if (k == 21) chk("s1_flag5_early", s_f5, 0);
      if (k == 22) begin
        chk("s1_flag5", s_f5, 1);
        chk("s1_elapsed", s_el, 5);
      end
    end

    // Dial then call with clear held low
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 12; k++) cyc(1'b0, 1'b1, 1'b0);
    chk("s2_dial_elapsed", s_el, 2);
    for (int k = 1; k <= 44; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("s2_flag5", s_f5, 0);
      if (k == 2)  chk("s2_elapsed", s_el, 0);
      if (k == 41) chk("s2_flag250_early", s_f250, 0);
      if (k == 42) chk("s2_flag250", s_f250, 1);
    end

    // Clear landing on a tick cycle
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++) cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("s3_elapsed_at_clear", s_el, 3);
    chk("s3_tick", s_tick, 0);
    cyc(1'b0, 1'b1, 1'b0);
    chk("s3_elapsed_after", s_el, 0);
    chk("s3_flag5", s_f5, 0);

    // Freeze while run is low
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 10; k++) cyc(1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      chk("s4_hold", s_el, 2);
    end
    for (int k = 1; k <= 3; k++) begin
      cyc(1'b0, 1'b1, 1'b0);
      chk("s4_tick", s_tick, (k == 3));
    end

    // Saturation: small instance at 7, then main instance at 255
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 60; k++) cyc(1'b0, 1'b0, 1'b1);
    chk("s5_s_elapsed", t_el, 7);
    chk("s5_s_flag250", t_f250, 1);
    for (int k = 61; k <= 1030; k++) cyc(1'b0, 1'b0, 1'b1);
    chk("s5_m_elapsed", s_el, 255);

    // Asynchronous reset mid-call, then fresh phase numbering
    cyc(1'b1, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) cyc(1'b0, 1'b0, 1'b1);
    chk("s6_pre_flag", t_f250, 1);
    async_reset();
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b0, 1'b0, 1'b1);
      chk("s6_tick", s_tick, (k == 5 || k == 9));
    end

    // Random phase traffic
    for (int seg = 0; seg < 40; seg++) begin
      int   len, sel;
      logic d, i;
      len = $urandom_range(1, 40);
      sel = $urandom_range(0, 3);
      d = (sel == 1 || sel == 3);
      i = (sel >= 2);
      for (int n = 0; n < len; n++) cyc(($urandom_range(0, 29) == 0), d, i);
      if ($urandom_range(0, 7) == 0) async_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
